// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry valid/ready skid buffer with state-only in_ready; optional stall counter under PIPE_SKID_STALL_CNT_EN
module pipe_skid_reg #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [15:0]  stall_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
    state_t state;
    logic [N-1:0] main_q, skid_q;
    logic in_fire, out_fire;
    assign in_ready  = (state != SKID) & ~reset;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    // state and data registers; data loads only on the transitions that need it
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    state  <= FULL;
                    main_q <= in_data;
                end
                FULL: if (in_fire && out_fire) begin
                    main_q <= in_data;
                end else if (in_fire) begin
                    state  <= SKID;
                    skid_q <= in_data;
                end else if (out_fire) begin
                    state <= EMPTY;
                end
                SKID: if (out_fire) begin
                    state  <= FULL;
                    main_q <= skid_q;
                end
                default: state <= EMPTY;
            endcase
        end
    end
`ifdef PIPE_SKID_STALL_CNT_EN
    // saturating count of downstream stall cycles, survives flush
    always_ff @(posedge clk) begin
        if (reset) stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: scoreboard bench for pipe_skid_reg (directed + random traffic)
module tb_pipe_skid_reg;
    logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_data = 0;
    logic in_ready, out_valid;
    logic [31:0] out_data;
    int checks = 0, failures = 0;
    logic [31:0] q[$];
    bit clr = 0, pstall = 0;
    logic [31:0] pdata;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    pipe_skid_reg #(.N(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_SKID_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one cycle: apply inputs after an edge, predict acceptance, advance to just past the next edge
    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        if (clr) begin
            q.delete();
            clr = 0;
        end
        in_valid = v; in_data = d; out_ready = r; flush = f;
        #1;
        if (reset || flush) clr = 1;
        else if (in_valid && in_ready) q.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    // monitor: pop and compare on every output transfer, check hold under stall
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("pop_when_empty", 1, 0);
                else check("order", out_data, q.pop_front());
            end
            if (pstall) check("stable", {out_valid, out_data}, {1'b1, pdata});
            pstall = out_valid && !out_ready && !flush;
            pdata = out_data;
        end else pstall = 0;
    end

    initial begin
        @(posedge clk); #1;
        drive(0, 0, 0, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 0; #1;
        check("post_rst_in_ready", in_ready, 1);
        // back-to-back streaming
        drive(1, 32'h11, 1, 0); check("t1_d0", out_data, 32'h11); check("t1_rdy0", in_ready, 1);
        drive(1, 32'h22, 1, 0); check("t1_d1", out_data, 32'h22); check("t1_rdy1", in_ready, 1);
        drive(1, 32'h33, 1, 0); check("t1_d2", out_data, 32'h33); check("t1_v2", out_valid, 1);
        drive(0, 0, 1, 0); check("t1_empty", out_valid, 0);
        // backpressure into skid
        drive(1, 32'hA, 0, 0); check("t2_full", out_data, 32'hA);
        drive(1, 32'hB, 0, 0); check("t2_skid_rdy", in_ready, 0); check("t2_hold", out_data, 32'hA);
        drive(0, 0, 0, 0); check("t2_hold2", out_data, 32'hA); check("t2_rdy2", in_ready, 0);
        drive(0, 0, 1, 0); check("t2_b", out_data, 32'hB); check("t2_rdy_back", in_ready, 1);
        drive(0, 0, 1, 0); check("t2_empty", out_valid, 0);
        // flush from SKID and from FULL with an offered word
        drive(1, 32'h1, 0, 0);
        drive(1, 32'h2, 0, 0);
        drive(1, 32'hC, 0, 1); check("t3_flush_v", out_valid, 0); check("t3_flush_rdy", in_ready, 1);
        drive(1, 32'h3, 0, 0);
        drive(1, 32'hC, 0, 1); check("t3_flush2_v", out_valid, 0);
        drive(0, 0, 1, 0); check("t3_no_c", out_valid, 0);
        // reset while in SKID
        drive(1, 32'h7, 0, 0);
        drive(1, 32'h8, 0, 0); check("t4_skid", in_ready, 0);
        reset = 1;
        drive(0, 0, 0, 0);
        check("t4_rst_v", out_valid, 0); check("t4_rst_d", out_data, 0); check("t4_rst_rdy", in_ready, 0);
        reset = 0; #1;
        check("t4_rdy_after", in_ready, 1);
        drive(1, 32'h5, 1, 0); check("t4_first", out_data, 32'h5); check("t4_first_v", out_valid, 1);
        drive(0, 0, 1, 0); check("t4_empty", out_valid, 0);
`ifdef PIPE_SKID_STALL_CNT_EN
        check("t6_cnt0", stall_cnt, 0);
        drive(1, 32'h9, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);
        check("t6_cnt5", stall_cnt, 5);
        drive(0, 0, 1, 1); check("t6_flush_keep", stall_cnt, 5);
        reset = 1;
        drive(0, 0, 0, 0); check("t6_rst", stall_cnt, 0);
        reset = 0;
`endif
        // random traffic against the scoreboard
        for (int i = 0; i < 10000; i++)
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
        check("drained", q.size(), 0);
        check("final_empty", out_valid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
